bcd_conversion_scheduler: RTL

//  Serial (one bit per clock) double-dabble binary-to-BCD engine shared by two requesters.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_add3_digit.sv | 13 +
 rtl/bcd_conversion_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial double-dabble BCD scheduler.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         DIGIT_W       = 4;
  localparam logic [3:0] ADD3_THRESH   = 4'd5;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'h9;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  // The result never exceeds 4'hC, so there is no carry out of the digit.
  assign digit_o = (digit_i >= ADD3_THRESH) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bcd_conversion_scheduler.sv
// One shared serial binary-to-BCD engine serving two requesters with
// round-robin arbitration and a tagged one-cycle result strobe.
module bcd_conversion_scheduler
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = 4
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   ReqA_Valid,
  input  logic [BIN_WIDTH-1:0]   ReqA_Binary,
  output logic                   ReqA_Ready,
  input  logic                   ReqB_Valid,
  input  logic [BIN_WIDTH-1:0]   ReqB_Binary,
  output logic                   ReqB_Ready,
  output logic [4*DIGITS-1:0]    Result_BCD,
  output logic                   Result_Overflow,
  output logic                   Result_Source,
  output logic                   Result_Valid
);

  localparam int               CNT_W    = $clog2(BIN_WIDTH);
  localparam int               BCD_W    = DIGIT_W * DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_WIDTH - 1);
  localparam logic [BCD_W-1:0] ALL_NINE = {DIGITS{BCD_MAX_DIGIT}};

  state_e                 state_q, state_d;
  logic                   last_b_q, last_b_d;    // 1: B held the most recent grant
  logic [BIN_WIDTH-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]       digits_q, digits_d;
  logic                   ovf_q, ovf_d;
  logic                   src_q, src_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BCD_W-1:0]       res_bcd_q, res_bcd_d;
  logic                   res_ovf_q, res_ovf_d;
  logic                   res_src_q, res_src_d;
  logic                   res_valid_q, res_valid_d;

  logic [BCD_W-1:0]       digits_adj;
  logic                   grant_a, grant_b;

  // Per-digit add-3 correction applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (digits_q[g*DIGIT_W +: DIGIT_W]),
      .digit_o (digits_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Round-robin: a lone requester wins; on contention the one not granted last wins.
  assign grant_a = ReqA_Valid & (~ReqB_Valid | last_b_q);
  assign grant_b = ReqB_Valid & (~ReqA_Valid | ~last_b_q);

  assign ReqA_Ready      = (state_q == IDLE) & grant_a;
  assign ReqB_Ready      = (state_q == IDLE) & grant_b;
  assign Result_BCD      = res_bcd_q;
  assign Result_Overflow = res_ovf_q;
  assign Result_Source   = res_src_q;
  assign Result_Valid    = res_valid_q;

  // Next-state and datapath control for IDLE -> SHIFT x BIN_WIDTH -> DONE.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    last_b_d    = last_b_q;
    shreg_d     = shreg_q;
    digits_d    = digits_q;
    ovf_d       = ovf_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    res_bcd_d   = res_bcd_q;
    res_ovf_d   = res_ovf_q;
    res_src_d   = res_src_q;
    res_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_a || grant_b) begin
          shreg_d  = grant_a ? ReqA_Binary : ReqB_Binary;
          src_d    = grant_b;
          last_b_d = grant_b;
          digits_d = '0;
          ovf_d    = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // The shift register MSB enters the ones digit; the top digit MSB falls off.
        {digits_d, shreg_d} = {digits_adj, shreg_q} << 1;
        ovf_d = ovf_q | digits_adj[BCD_W-1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        res_bcd_d   = ovf_q ? ALL_NINE : digits_q;
        res_ovf_d   = ovf_q;
        res_src_d   = src_q;
        res_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      shreg_q     <= '0;
      digits_q    <= '0;
      ovf_q       <= 1'b0;
      src_q       <= 1'b0;
      cnt_q       <= '0;
      res_bcd_q   <= '0;
      res_ovf_q   <= 1'b0;
      res_src_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      shreg_q     <= shreg_d;
      digits_q    <= digits_d;
      ovf_q       <= ovf_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      res_bcd_q   <= res_bcd_d;
      res_ovf_q   <= res_ovf_d;
      res_src_q   <= res_src_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule
